// File: rtl/stdp_synapse.sv
// Plastic synapse feeding a LIF neuron: weight-scaled input current plus
// pair-wise shift-based STDP driven by pre/post spike age traces.
module stdp_trace #(
    parameter int TRACE_MAX = 15,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spike,
    output logic [AW-1:0] age,
    output logic          valid
);
    localparam logic [AW-1:0] AGE_LAST = AW'(TRACE_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age   <= '0;
            valid <= 1'b0;
        end else if (spike) begin
            age   <= '0;
            valid <= 1'b1;
        end else if (valid) begin
            // Age saturates at the last valid value while the trace expires.
            if (age == AGE_LAST) valid <= 1'b0;
            else                 age   <= age + 1'b1;
        end
    end
endmodule

module stdp_synapse #(
    parameter int W_INIT    = 64,
    parameter int W_MAX     = 255,
    parameter int W_MIN     = 0,
    parameter int A_PLUS    = 8,
    parameter int A_MINUS   = 6,
    parameter int TRACE_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_spike,
    input  logic       post_spike,
    input  logic       learn_en,
    output logic [7:0] current,
    output logic [7:0] weight,
    output logic       ltp_pulse,
    output logic       ltd_pulse
);
    localparam int AW = $clog2(TRACE_MAX + 1);
    localparam logic [7:0]        AP     = 8'(A_PLUS);
    localparam logic [7:0]        AM     = 8'(A_MINUS);
    localparam logic [8:0]        WMAX9  = 9'(W_MAX);
    localparam logic signed [9:0] WMIN10 = 10'(W_MIN);

    logic [AW-1:0] pre_age, post_age;
    logic          pre_valid, post_valid;

    stdp_trace #(.TRACE_MAX(TRACE_MAX), .AW(AW)) u_pre_trace (
        .clk(clk), .rst_n(rst_n), .spike(pre_spike), .age(pre_age), .valid(pre_valid)
    );
    stdp_trace #(.TRACE_MAX(TRACE_MAX), .AW(AW)) u_post_trace (
        .clk(clk), .rst_n(rst_n), .spike(post_spike), .age(post_age), .valid(post_valid)
    );

    logic [7:0]        dp, dd;
    logic [8:0]        sum9;
    logic signed [9:0] diff;
    logic              ltp_cond, ltd_cond;
    logic [7:0]        w_up, w_dn;

    // Step halves for every 4 cycles of age; simultaneous spikes cancel out.
    always_comb begin
        dp       = AP >> (pre_age >> 2);
        dd       = AM >> (post_age >> 2);
        ltp_cond = post_spike && !pre_spike && pre_valid && learn_en;
        ltd_cond = pre_spike && !post_spike && post_valid && learn_en;
        sum9     = {1'b0, weight} + {1'b0, dp};
        diff     = $signed({2'b00, weight}) - $signed({2'b00, dd});
        w_up     = (sum9 > WMAX9) ? WMAX9[7:0] : sum9[7:0];
        w_dn     = (diff < WMIN10) ? WMIN10[7:0] : diff[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight    <= 8'(W_INIT);
            current   <= '0;
            ltp_pulse <= 1'b0;
            ltd_pulse <= 1'b0;
        end else begin
            current   <= pre_spike ? weight : 8'd0;
            ltp_pulse <= ltp_cond;
            ltd_pulse <= ltd_cond;
            if (ltp_cond)      weight <= w_up;
            else if (ltd_cond) weight <= w_dn;
        end
    end
endmodule

// File: tb/tb_stdp_synapse.sv
// Directed STDP scenarios; expectations queued at stimulus time and checked
// by an independent monitor on the falling edge.
module tb_stdp_synapse;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pre_spike = 1'b0, post_spike = 1'b0, learn_en = 1'b1;
    logic [7:0] current, weight;
    logic       ltp_pulse, ltd_pulse;

    stdp_synapse dut (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
        .learn_en(learn_en), .current(current), .weight(weight),
        .ltp_pulse(ltp_pulse), .ltd_pulse(ltd_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] cur;
        logic [7:0] w;
        logic       ltp;
        logic       ltd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0, n_err = 0;
    bit   done = 0;

    // Monitor: compares the queued expectation belonging to the current cycle.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (current !== e.cur || weight !== e.w || ltp_pulse !== e.ltp || ltd_pulse !== e.ltd) begin
                n_err++;
                $display("FAIL %s cyc %0d: got cur=%0d w=%0d ltp=%0b ltd=%0b, expected cur=%0d w=%0d ltp=%0b ltd=%0b",
                         e.name, cyc, current, weight, ltp_pulse, ltd_pulse, e.cur, e.w, e.ltp, e.ltd);
            end
        end
    end

    task automatic tick(input logic pre, input logic post);
        pre_spike  = pre;
        post_spike = post;
        @(posedge clk);
        #1;
        cyc++;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
    endtask

    task automatic chk(input logic pre, input logic post, input string name,
                       input logic [7:0] ecur, input logic [7:0] ew,
                       input logic eltp, input logic eltd);
        exp_t e;
        e.cyc = cyc + 1; e.name = name; e.cur = ecur; e.w = ew; e.ltp = eltp; e.ltd = eltd;
        q.push_back(e);
        tick(pre, post);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        tick(1'b0, 1'b0);
        chk(1'b0, 1'b0, name, 8'd0, 8'd64, 1'b0, 1'b0);
        rst_n = 1'b1;
        learn_en = 1'b1;
    endtask

    initial begin
        logic [7:0] ew;

        // Reset and current pass-through
        do_reset("reset_state");
        idle(2);
        chk(1, 0, "pass_cur64", 8'd64, 8'd64, 0, 0);
        chk(0, 0, "pass_cur0", 8'd0, 8'd64, 0, 0);

        // LTP at age 0, 4, 15, and expired
        do_reset("rst_ltp0");
        tick(1, 0);
        chk(0, 1, "ltp_age0", 8'd0, 8'd72, 1, 0);
        chk(0, 0, "ltp_pulse_drop", 8'd0, 8'd72, 0, 0);

        do_reset("rst_ltp4");
        tick(1, 0); idle(4);
        chk(0, 1, "ltp_age4", 8'd0, 8'd68, 1, 0);

        do_reset("rst_ltp15");
        tick(1, 0); idle(15);
        chk(0, 1, "ltp_age15", 8'd0, 8'd65, 1, 0);

        do_reset("rst_ltp_exp");
        tick(1, 0); idle(16);
        chk(0, 1, "ltp_expired", 8'd0, 8'd64, 0, 0);

        // LTD at age 0
        do_reset("rst_ltd0");
        chk(0, 1, "ltd_post", 8'd0, 8'd64, 0, 0);
        chk(1, 0, "ltd_age0", 8'd64, 8'd58, 0, 1);
        chk(0, 0, "ltd_after", 8'd0, 8'd58, 0, 0);

        // LTD clamp at 0
        do_reset("rst_clamp0");
        ew = 8'd64;
        for (int i = 0; i < 12; i++) begin
            tick(0, 1);
            chk(1, 0, "ltd_clamp", ew, (ew >= 8'd6) ? ew - 8'd6 : 8'd0, 0, 1);
            ew = (ew >= 8'd6) ? ew - 8'd6 : 8'd0;
            idle(17);
        end
        chk(0, 0, "ltd_floor", 8'd0, 8'd0, 0, 0);

        // LTP clamp at 255
        do_reset("rst_clamp255");
        ew = 8'd64;
        for (int i = 0; i < 25; i++) begin
            tick(1, 0);
            chk(0, 1, "ltp_clamp", 8'd0, (ew > 8'd247) ? 8'd255 : ew + 8'd8, 1, 0);
            ew = (ew > 8'd247) ? 8'd255 : ew + 8'd8;
            idle(17);
        end
        chk(0, 0, "ltp_ceiling", 8'd0, 8'd255, 0, 0);

        // Simultaneous spikes: no update, both traces restart at age 0
        do_reset("rst_sim");
        tick(1, 0);
        chk(0, 1, "sim_setup", 8'd0, 8'd72, 1, 0);
        chk(1, 1, "sim_noupd", 8'd72, 8'd72, 0, 0);
        chk(0, 1, "sim_pre_age0", 8'd0, 8'd80, 1, 0);
        chk(1, 1, "sim_noupd2", 8'd80, 8'd80, 0, 0);
        chk(1, 0, "sim_post_age0", 8'd80, 8'd74, 0, 1);

        // learn_en gating: frozen weight, traces keep running
        do_reset("rst_learn");
        learn_en = 1'b0;
        tick(1, 0);
        chk(0, 1, "learn_off", 8'd0, 8'd64, 0, 0);
        learn_en = 1'b1;
        chk(0, 1, "learn_trace_ran", 8'd0, 8'd72, 1, 0);
        idle(17);
        tick(1, 0); idle(1);
        chk(0, 1, "learn_on", 8'd0, 8'd80, 1, 0);

        // Reset mid-trace discards pre trace
        do_reset("rst_mid");
        tick(1, 0); idle(1);
        rst_n = 1'b0;
        chk(0, 0, "mid_reset", 8'd0, 8'd64, 0, 0);
        rst_n = 1'b1;
        idle(1);
        chk(0, 1, "mid_no_ltp", 8'd0, 8'd64, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
